// File: rtl/mem_access_unit.sv
// Purpose : MEM-stage initiator for the data memory; turns load/store requests into pin activity and returns load results.
// Latency : a store completes at its accepting edge; load data is presented two cycles after the load is accepted.
// Backpressure: one load in flight; requests stall during the read wait and while a response is held for i_rsp_ready.
module mem_access_unit #(
   parameter int p_WORD_LEN = 16,
   parameter int p_ADDR_LEN = 10,
   parameter int p_TAG_LEN  = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_we,
   input  logic [p_ADDR_LEN-1:0] i_req_addr,
   input  logic [p_WORD_LEN-1:0] i_req_wdata,
   input  logic [p_TAG_LEN-1:0]  i_req_tag,
   output logic                  o_mem_wr_en,
   output logic [p_ADDR_LEN-1:0] o_mem_addr,
   output logic [p_WORD_LEN-1:0] o_mem_wr_data,
   input  logic [p_WORD_LEN-1:0] i_mem_rd_data,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [p_WORD_LEN-1:0] o_rsp_data,
   output logic [p_TAG_LEN-1:0]  o_rsp_tag,
   output logic                  o_busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RSP     = 2'd2
   } state_t;

   state_t                r_state;
   logic [p_ADDR_LEN-1:0] r_addr;
   logic [p_WORD_LEN-1:0] r_rsp_data;
   logic [p_TAG_LEN-1:0]  r_rsp_tag;

   logic                  accept;
   logic                  load_accept;
   logic                  rsp_handshake;

   // A held response that leaves this cycle frees the unit for a new request in the same cycle.
   assign o_req_ready   = !i_rst && ((r_state == IDLE) || ((r_state == RSP) && i_rsp_ready));
   assign accept        = i_req_valid && o_req_ready;
   assign load_accept   = accept && !i_req_we;
   assign rsp_handshake = o_rsp_valid && i_rsp_ready;

   // Memory pins follow the request combinationally so the memory acts on the accepting edge;
   // between accepts the address holds so the registered read stays pointed at the load address.
   assign o_mem_addr    = accept ? i_req_addr : r_addr;
   assign o_mem_wr_en   = accept && i_req_we;
   assign o_mem_wr_data = i_req_wdata;

   assign o_rsp_valid   = !i_rst && (r_state == RSP);
   assign o_rsp_data    = r_rsp_data;
   assign o_rsp_tag     = r_rsp_tag;
   assign o_busy        = (r_state != IDLE);

   // Request/response sequencing: latch tag at load accept, capture read data one cycle later,
   // hold the result until the consumer takes it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_rsp_data <= '0;
         r_rsp_tag  <= '0;
      end else begin
         if (accept) begin
            r_addr <= i_req_addr;
         end
         case (r_state)
            IDLE: begin
               if (load_accept) begin
                  r_rsp_tag <= i_req_tag;
                  r_state   <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               r_rsp_data <= i_mem_rd_data;
               r_state    <= RSP;
            end
            RSP: begin
               if (rsp_handshake) begin
                  if (load_accept) begin
                     r_rsp_tag <= i_req_tag;
                     r_state   <= RD_WAIT;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose : self-checking bench for mem_access_unit with a registered-read memory behind it.
// Latency : directed vectors, two hand sequences, then a randomized run against a transaction-level model.
// Backpressure: i_rsp_ready is driven by the stimulus to exercise response holding.
module tb_mem_access_unit;

   localparam int W = 16;
   localparam int A = 10;
   localparam int T = 3;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic         i_req_valid;
   logic         o_req_ready;
   logic         i_req_we;
   logic [A-1:0] i_req_addr;
   logic [W-1:0] i_req_wdata;
   logic [T-1:0] i_req_tag;
   logic         o_mem_wr_en;
   logic [A-1:0] o_mem_addr;
   logic [W-1:0] o_mem_wr_data;
   logic [W-1:0] i_mem_rd_data;
   logic         o_rsp_valid;
   logic         i_rsp_ready;
   logic [W-1:0] o_rsp_data;
   logic [T-1:0] o_rsp_tag;
   logic         o_busy;

   int checks   = 0;
   int failures = 0;

   always #5 i_clk = ~i_clk;

   mem_access_unit #(
      .p_WORD_LEN(W),
      .p_ADDR_LEN(A),
      .p_TAG_LEN (T)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .i_req_we     (i_req_we),
      .i_req_addr   (i_req_addr),
      .i_req_wdata  (i_req_wdata),
      .i_req_tag    (i_req_tag),
      .o_mem_wr_en  (o_mem_wr_en),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wr_data(o_mem_wr_data),
      .i_mem_rd_data(i_mem_rd_data),
      .o_rsp_valid  (o_rsp_valid),
      .i_rsp_ready  (i_rsp_ready),
      .o_rsp_data   (o_rsp_data),
      .o_rsp_tag    (o_rsp_tag),
      .o_busy       (o_busy)
   );

   // Data memory: writes and registered reads both happen on the clock edge.
   logic [W-1:0] mem_arr [0:(1<<A)-1];
   always @(posedge i_clk) begin
      if (o_mem_wr_en) mem_arr[o_mem_addr] <= o_mem_wr_data;
      i_mem_rd_data <= mem_arr[o_mem_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Inputs change at the falling edge; outputs are looked at 1ns later, well before the rising edge.
   task automatic drive(input logic rst, input logic v, input logic we, input logic [A-1:0] a,
                        input logic [W-1:0] wd, input logic [T-1:0] tg, input logic rr);
      @(negedge i_clk);
      i_rst       = rst;
      i_req_valid = v;
      i_req_we    = we;
      i_req_addr  = a;
      i_req_wdata = wd;
      i_req_tag   = tg;
      i_rsp_ready = rr;
      #1;
   endtask

   typedef struct {
      logic         rst, v, we;
      logic [A-1:0] a;
      logic [W-1:0] wd;
      logic [T-1:0] tg;
      logic         rr;
      logic         e_rdy, e_we;
      logic [A-1:0] e_a;
      logic         e_rv;
      logic [W-1:0] e_d;
      logic [T-1:0] e_t;
      logic         e_busy;
   } vec_t;

   vec_t vt [21];

   typedef struct {
      logic [W-1:0] d;
      logic [T-1:0] t;
      int           vis;
   } pend_t;

   pend_t        pq [$];
   pend_t        p;
   logic [W-1:0] ref_mem [0:(1<<A)-1];
   logic [A-1:0] ref_last;
   logic         r_v, r_we, r_rr, e_rv, e_rdy, acc;
   logic [A-1:0] r_a;
   logic [W-1:0] r_wd;
   logic [T-1:0] r_tg;
   int           n_acc;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < (1<<A); i++) mem_arr[i] = '0;

      //          rst   v     we    addr     wdata     tag   rr  | rdy   we    addr     rv    data      tag   busy
      vt[0]  = '{1'b1, 1'b1, 1'b0, 10'h055, 16'h0000, 3'd5, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 16'h0000, 3'd0, 1'b0};
      vt[1]  = '{1'b0, 1'b1, 1'b1, 10'h005, 16'hBEEF, 3'd0, 1'b1, 1'b1, 1'b1, 10'h005, 1'b0, 16'h0000, 3'd0, 1'b0};
      vt[2]  = '{1'b0, 1'b1, 1'b0, 10'h005, 16'h0000, 3'd3, 1'b1, 1'b1, 1'b0, 10'h005, 1'b0, 16'h0000, 3'd0, 1'b0};
      vt[3]  = '{1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 10'h005, 1'b0, 16'h0000, 3'd0, 1'b1};
      vt[4]  = '{1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 10'h005, 1'b1, 16'hBEEF, 3'd3, 1'b1};
      vt[5]  = '{1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 10'h005, 1'b1, 16'hBEEF, 3'd3, 1'b1};
      vt[6]  = '{1'b0, 1'b1, 1'b1, 10'h3FF, 16'h1111, 3'd0, 1'b1, 1'b1, 1'b1, 10'h3FF, 1'b0, 16'h0000, 3'd0, 1'b0};
      vt[7]  = '{1'b0, 1'b1, 1'b1, 10'h000, 16'h2222, 3'd0, 1'b1, 1'b1, 1'b1, 10'h000, 1'b0, 16'h0000, 3'd0, 1'b0};
      vt[8]  = '{1'b0, 1'b1, 1'b0, 10'h3FF, 16'h0000, 3'd6, 1'b1, 1'b1, 1'b0, 10'h3FF, 1'b0, 16'h0000, 3'd0, 1'b0};
      vt[9]  = '{1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 10'h3FF, 1'b0, 16'h0000, 3'd0, 1'b1};
      vt[10] = '{1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 10'h3FF, 1'b1, 16'h1111, 3'd6, 1'b1};
      vt[11] = '{1'b0, 1'b1, 1'b0, 10'h123, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b0, 10'h123, 1'b0, 16'h0000, 3'd0, 1'b0};
      vt[12] = '{1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 10'h123, 1'b0, 16'h0000, 3'd0, 1'b1};
      vt[13] = '{1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 10'h123, 1'b1, 16'h0000, 3'd1, 1'b1};
      vt[14] = '{1'b0, 1'b1, 1'b0, 10'h000, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b0, 10'h000, 1'b0, 16'h0000, 3'd0, 1'b0};
      vt[15] = '{1'b1, 1'b1, 1'b1, 10'h0AA, 16'hDEAD, 3'd0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 16'h0000, 3'd0, 1'b1};
      vt[16] = '{1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 10'h000, 1'b0, 16'h0000, 3'd0, 1'b0};
      vt[17] = '{1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 10'h000, 1'b0, 16'h0000, 3'd0, 1'b0};
      vt[18] = '{1'b0, 1'b1, 1'b0, 10'h005, 16'h0000, 3'd7, 1'b1, 1'b1, 1'b0, 10'h005, 1'b0, 16'h0000, 3'd0, 1'b0};
      vt[19] = '{1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 10'h005, 1'b0, 16'h0000, 3'd0, 1'b1};
      vt[20] = '{1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 10'h005, 1'b1, 16'hBEEF, 3'd7, 1'b1};

      drive(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);

      // Directed vectors: RAW store->load, back-to-back stores at the address extremes,
      // never-written address, reset during the read wait.
      for (int i = 0; i < 21; i++) begin
         drive(vt[i].rst, vt[i].v, vt[i].we, vt[i].a, vt[i].wd, vt[i].tg, vt[i].rr);
         chk($sformatf("vec%0d ready", i),  32'(o_req_ready), 32'(vt[i].e_rdy));
         chk($sformatf("vec%0d wr_en", i),  32'(o_mem_wr_en), 32'(vt[i].e_we));
         chk($sformatf("vec%0d addr", i),   32'(o_mem_addr),  32'(vt[i].e_a));
         chk($sformatf("vec%0d rsp_vld", i), 32'(o_rsp_valid), 32'(vt[i].e_rv));
         chk($sformatf("vec%0d busy", i),   32'(o_busy),      32'(vt[i].e_busy));
         if (vt[i].e_we) chk($sformatf("vec%0d wr_data", i), 32'(o_mem_wr_data), 32'(vt[i].wd));
         if (vt[i].e_rv) begin
            chk($sformatf("vec%0d rsp_data", i), 32'(o_rsp_data), 32'(vt[i].e_d));
            chk($sformatf("vec%0d rsp_tag", i),  32'(o_rsp_tag),  32'(vt[i].e_t));
         end
      end

      // Held response: five stalled cycles with a competing load, then same-cycle accept on release.
      drive(1'b0, 1'b1, 1'b1, 10'h010, 16'hA5A5, 3'd0, 1'b1);
      chk("hold store wr_en", 32'(o_mem_wr_en), 32'd1);
      drive(1'b0, 1'b1, 1'b0, 10'h010, 16'h0000, 3'd4, 1'b1);
      chk("hold load ready", 32'(o_req_ready), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 3'd0, 1'b1);
      chk("hold rdwait rsp_vld", 32'(o_rsp_valid), 32'd0);
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b1, 1'b0, 10'h005, 16'h0000, 3'd5, 1'b0);
         chk($sformatf("hold%0d rsp_vld", k), 32'(o_rsp_valid), 32'd1);
         chk($sformatf("hold%0d data", k),    32'(o_rsp_data),  32'hA5A5);
         chk($sformatf("hold%0d tag", k),     32'(o_rsp_tag),   32'd4);
         chk($sformatf("hold%0d ready", k),   32'(o_req_ready), 32'd0);
      end
      drive(1'b0, 1'b1, 1'b0, 10'h005, 16'h0000, 3'd5, 1'b1);
      chk("release ready", 32'(o_req_ready), 32'd1);
      chk("release rsp_vld", 32'(o_rsp_valid), 32'd1);
      chk("release tag", 32'(o_rsp_tag), 32'd4);
      drive(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 3'd0, 1'b1);
      chk("next rdwait rsp_vld", 32'(o_rsp_valid), 32'd0);
      chk("next rdwait busy", 32'(o_busy), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 3'd0, 1'b1);
      chk("next rsp data", 32'(o_rsp_data), 32'hBEEF);
      chk("next rsp tag",  32'(o_rsp_tag),  32'd5);

      // Four loads offered continuously with the consumer always ready: one accept every 2 cycles.
      n_acc = 0;
      for (int c = 0; c < 9; c++) begin
         logic [A-1:0] la;
         logic [W-1:0] ld;
         case (n_acc)
            0:       la = 10'h005;
            1:       la = 10'h3FF;
            2:       la = 10'h000;
            default: la = 10'h123;
         endcase
         drive(1'b0, n_acc < 4, 1'b0, la, 16'h0000, 3'(n_acc + 1), 1'b1);
         chk($sformatf("stream c%0d ready", c),   32'(o_req_ready), 32'(c % 2 == 0));
         chk($sformatf("stream c%0d rsp_vld", c), 32'(o_rsp_valid), 32'(c >= 2 && c % 2 == 0));
         if (c >= 2 && c % 2 == 0) begin
            case (c / 2 - 1)
               0:       ld = 16'hBEEF;
               1:       ld = 16'h1111;
               2:       ld = 16'h2222;
               default: ld = 16'h0000;
            endcase
            chk($sformatf("stream c%0d data", c), 32'(o_rsp_data), 32'(ld));
            chk($sformatf("stream c%0d tag", c),  32'(o_rsp_tag),  32'(c / 2));
         end
         if (c % 2 == 0 && n_acc < 4) n_acc++;
      end

      // Randomized run: at most one load outstanding; its result (memory contents at accept time)
      // becomes visible two cycles after accept and leaves when the consumer is ready.
      for (int i = 0; i < (1<<A); i++) ref_mem[i] = '0;
      ref_mem[10'h005] = 16'hBEEF;
      ref_mem[10'h3FF] = 16'h1111;
      ref_mem[10'h000] = 16'h2222;
      ref_mem[10'h010] = 16'hA5A5;
      ref_last = 10'h123;
      for (int cyc = 0; cyc < 400; cyc++) begin
         r_v  = ($urandom_range(0, 9) < 7);
         r_we = 1'($urandom_range(0, 1));
         r_rr = ($urandom_range(0, 9) < 6);
         r_wd = 16'($urandom);
         r_tg = 3'($urandom);
         case ($urandom_range(0, 5))
            0:       r_a = 10'h000;
            1:       r_a = 10'h005;
            2:       r_a = 10'h010;
            3:       r_a = 10'h3FF;
            4:       r_a = 10'h123;
            default: r_a = 10'h200 + 10'($urandom_range(0, 7));
         endcase
         e_rv  = (pq.size() > 0) && (cyc >= pq[0].vis);
         e_rdy = (pq.size() == 0) || (e_rv && r_rr);
         acc   = r_v && e_rdy;
         drive(1'b0, r_v, r_we, r_a, r_wd, r_tg, r_rr);
         chk($sformatf("rnd%0d ready", cyc),   32'(o_req_ready), 32'(e_rdy));
         chk($sformatf("rnd%0d rsp_vld", cyc), 32'(o_rsp_valid), 32'(e_rv));
         chk($sformatf("rnd%0d wr_en", cyc),   32'(o_mem_wr_en), 32'(acc && r_we));
         chk($sformatf("rnd%0d addr", cyc),    32'(o_mem_addr),  32'(acc ? r_a : ref_last));
         chk($sformatf("rnd%0d busy", cyc),    32'(o_busy),      32'(pq.size() > 0));
         if (e_rv) begin
            chk($sformatf("rnd%0d data", cyc), 32'(o_rsp_data), 32'(pq[0].d));
            chk($sformatf("rnd%0d tag", cyc),  32'(o_rsp_tag),  32'(pq[0].t));
            if (r_rr) void'(pq.pop_front());
         end
         if (acc) begin
            ref_last = r_a;
            if (r_we) begin
               ref_mem[r_a] = r_wd;
            end else begin
               p.d   = ref_mem[r_a];
               p.t   = r_tg;
               p.vis = cyc + 2;
               pq.push_back(p);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
